// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU data-port bus between the CPU and the memory responder
interface data_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] memAddr_i;
  logic [DATA_W-1:0] memData_i;
  logic              memRead_i;
  logic              memWrite_i;
  logic [DATA_W-1:0] memData_o;

  modport master (
    output memAddr_i,
    output memData_i,
    output memRead_i,
    output memWrite_i,
    input  memData_o
  );

  modport slave (
    input  memAddr_i,
    input  memData_i,
    input  memRead_i,
    input  memWrite_i,
    output memData_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM plus GPIO/timer MMIO page behind the CPU data port
module data_mem_responder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                RAM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_mem_responder_if.slave bus,
  output logic [DATA_W-1:0]  gpio_o,
  output logic               timer_irq_o
);
  localparam int                RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] A_GPIO    = MMIO_BASE;
  localparam logic [ADDR_W-1:0] A_CTRL    = MMIO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RELOAD  = MMIO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COUNT   = MMIO_BASE + ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS  = MMIO_BASE + ADDR_W'(4);

  logic [DATA_W-1:0] r_ram [RAM_DEPTH];
  logic [DATA_W-1:0] r_gpio;
  logic [1:0]        r_ctrl;
  logic [DATA_W-1:0] r_reload;
  logic [DATA_W-1:0] r_count;
  logic              r_expired;

  logic              w_is_ram;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_gpio;
  logic              w_wr_ctrl;
  logic              w_wr_reload;
  logic              w_wr_status;
  logic [DATA_W-1:0] w_rdata;
  logic [1:0]        w_ctrl_nxt;
  logic [DATA_W-1:0] w_count_nxt;
  logic              w_expired_nxt;
  logic              w_fire;

  assign w_is_ram    = {1'b0, bus.memAddr_i} < RAM_LIMIT;
  assign w_ram_idx   = bus.memAddr_i[RAM_AW-1:0];
  assign w_wr_gpio   = bus.memWrite_i && (bus.memAddr_i == A_GPIO);
  assign w_wr_ctrl   = bus.memWrite_i && (bus.memAddr_i == A_CTRL);
  assign w_wr_reload = bus.memWrite_i && (bus.memAddr_i == A_RELOAD);
  assign w_wr_status = bus.memWrite_i && (bus.memAddr_i == A_STATUS);

  // Read path sees pre-edge state, so read-during-write returns the old word.
  always_comb begin
    w_rdata = '0;
    if (bus.memRead_i) begin
      if (w_is_ram) begin
        w_rdata = r_ram[w_ram_idx];
      end else begin
        case (bus.memAddr_i)
          A_GPIO:   w_rdata = r_gpio;
          A_CTRL:   w_rdata = {{(DATA_W-2){1'b0}}, r_ctrl};
          A_RELOAD: w_rdata = r_reload;
          A_COUNT:  w_rdata = r_count;
          A_STATUS: w_rdata = {{(DATA_W-1){1'b0}}, r_expired};
          default:  w_rdata = '0;
        endcase
      end
    end
  end

  assign bus.memData_o = w_rdata;

  // A CTRL write pre-empts the tick; an expiry overrides a same-cycle STATUS clear.
  always_comb begin
    w_ctrl_nxt    = r_ctrl;
    w_count_nxt   = r_count;
    w_expired_nxt = r_expired;
    w_fire        = 1'b0;
    if (w_wr_ctrl) begin
      w_ctrl_nxt = bus.memData_i[1:0];
      if (bus.memData_i[0]) begin
        w_count_nxt = r_reload;
      end
    end else if (r_ctrl[0]) begin
      if (r_count != '0) begin
        w_count_nxt = r_count - DATA_W'(1);
      end else begin
        w_fire = 1'b1;
        if (r_ctrl[1]) begin
          w_count_nxt = r_reload;
        end else begin
          w_ctrl_nxt[0] = 1'b0;
        end
      end
    end
    if (w_wr_status && bus.memData_i[0]) begin
      w_expired_nxt = 1'b0;
    end
    if (w_fire) begin
      w_expired_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gpio    <= '0;
      r_ctrl    <= '0;
      r_reload  <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      if (w_wr_gpio) begin
        r_gpio <= bus.memData_i;
      end
      if (w_wr_reload) begin
        r_reload <= bus.memData_i;
      end
      r_ctrl    <= w_ctrl_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (bus.memWrite_i && w_is_ram) begin
      r_ram[w_ram_idx] <= bus.memData_i;
    end
  end

  assign gpio_o      = r_gpio;
  assign timer_irq_o = r_expired;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench for data_mem_responder with a behavioural model
module tb_data_mem_responder;
  logic        clk;
  logic        rst;
  logic [15:0] gpio;
  logic        irq;
  logic [15:0] last_rd;
  int          n_total;
  int          n_bad;

  data_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  data_mem_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .gpio_o      (gpio),
    .timer_irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state of the memory and I/O page.
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [15:0] m_gpio, m_reload, m_count;
  logic [1:0]  m_ctrl;
  bit          m_expired;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a, input bit rd);
    if (!rd) return 16'h0;
    if (a < 16'd256) return m_ram[a[7:0]];
    case (a)
      16'hFF00: return m_gpio;
      16'hFF01: return {14'h0, m_ctrl};
      16'hFF02: return m_reload;
      16'hFF03: return m_count;
      16'hFF04: return {15'h0, m_expired};
      default:  return 16'h0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input logic [15:0] a, input logic [15:0] d, input bit wr);
    logic [15:0] old_reload, old_count;
    logic [1:0]  old_ctrl;
    bit          expiry;
    if (wr && a < 16'd256) begin
      m_ram[a[7:0]]   = d;
      m_known[a[7:0]] = 1'b1;
    end
    if (r) begin
      m_gpio = 0; m_ctrl = 0; m_reload = 0; m_count = 0; m_expired = 0;
      return;
    end
    old_reload = m_reload;
    old_count  = m_count;
    old_ctrl   = m_ctrl;
    expiry     = 1'b0;
    if (wr && a == 16'hFF00) m_gpio = d;
    if (wr && a == 16'hFF02) m_reload = d;
    if (wr && a == 16'hFF01) begin
      m_ctrl = d[1:0];
      if (d[0]) m_count = old_reload;
    end else if (old_ctrl[0]) begin
      if (old_count > 0) begin
        m_count = old_count - 16'd1;
      end else begin
        expiry = 1'b1;
        if (old_ctrl[1]) m_count = old_reload;
        else             m_ctrl  = {old_ctrl[1], 1'b0};
      end
    end
    if (wr && a == 16'hFF04 && d[0]) m_expired = 1'b0;
    if (expiry) m_expired = 1'b1;
  endtask

  task automatic cyc(input bit r, input logic [15:0] a, input logic [15:0] d, input bit rd, input bit wr);
    @(negedge clk);
    rst            = r;
    bus.memAddr_i  = a;
    bus.memData_i  = d;
    bus.memRead_i  = rd;
    bus.memWrite_i = wr;
    #1;
    last_rd = bus.memData_o;
    if (!(rd && a < 16'd256 && !m_known[a[7:0]]))
      check("rdata", bus.memData_o, model_read(a, rd));
    @(posedge clk);
    model_edge(r, a, d, wr);
    #1;
    check("gpio", gpio, m_gpio);
    check("irq", {15'h0, irq}, {15'h0, m_expired});
  endtask

  function automatic logic [15:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 4) return 16'($urandom_range(0, 15));
    if (sel == 5) return 16'($urandom_range(0, 255));
    if (sel <= 8) return 16'hFF00 + 16'($urandom_range(0, 5));
    return 16'h0100 + 16'($urandom_range(0, 16'hFDFF));
  endfunction

  initial begin
    logic [15:0] a, d;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.memAddr_i = 0; bus.memData_i = 0; bus.memRead_i = 0; bus.memWrite_i = 0;
    m_gpio = 0; m_ctrl = 0; m_reload = 0; m_count = 0; m_expired = 0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    cyc(1, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'hFF00 + 16'(i), 16'h0, 1, 0);
      check("mmio_reset_rd", last_rd, 16'h0);
    end
    check("gpio_reset", gpio, 16'h0);
    check("irq_reset", {15'h0, irq}, 16'h0);

    cyc(0, 16'h0005, 16'h1234, 0, 1);
    cyc(0, 16'h0005, 16'h0, 1, 0);
    check("ram_rd", last_rd, 16'h1234);
    cyc(0, 16'h0005, 16'hBEEF, 1, 1);
    check("ram_rdw_old", last_rd, 16'h1234);
    cyc(0, 16'h0005, 16'h0, 1, 0);
    check("ram_rdw_new", last_rd, 16'hBEEF);

    cyc(0, 16'hFF00, 16'h00A5, 0, 1);
    check("gpio_wr", gpio, 16'h00A5);
    cyc(0, 16'h0300, 16'h0, 1, 0);
    check("unmapped_rd", last_rd, 16'h0);
    cyc(0, 16'h0300, 16'hFFFF, 0, 1);
    check("unmapped_wr", gpio, 16'h00A5);

    cyc(0, 16'hFF02, 16'd3, 0, 1);
    cyc(0, 16'hFF01, 16'h1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 16'hFF03, 16'h0, 1, 0);
      check("oneshot_count", last_rd, 16'(3 - i));
    end
    check("oneshot_irq", {15'h0, irq}, 16'h1);
    cyc(0, 16'hFF01, 16'h0, 1, 0);
    check("oneshot_ctrl", last_rd, 16'h0);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    check("oneshot_hold", last_rd, 16'h0);

    cyc(0, 16'hFF04, 16'h1, 0, 1);
    check("status_clr", {15'h0, irq}, 16'h0);
    cyc(0, 16'hFF02, 16'd2, 0, 1);
    cyc(0, 16'hFF01, 16'h3, 0, 1);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    check("auto_count2", last_rd, 16'd2);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    check("auto_count1", last_rd, 16'd1);
    cyc(0, 16'hFF04, 16'h1, 0, 1);
    check("auto_set_wins", {15'h0, irq}, 16'h1);
    cyc(0, 16'hFF04, 16'h1, 0, 1);
    check("auto_clear", {15'h0, irq}, 16'h0);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    check("auto_reloaded", last_rd, 16'd1);

    cyc(0, 16'hFF02, 16'd7, 0, 1);
    cyc(0, 16'hFF01, 16'h1, 0, 1);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    cyc(1, 16'hFF03, 16'h0, 1, 0);
    check("pre_reset_count", last_rd, 16'd5);
    cyc(0, 16'hFF03, 16'h0, 1, 0);
    check("post_reset_count", last_rd, 16'h0);
    cyc(0, 16'hFF01, 16'h0, 1, 0);
    check("post_reset_ctrl", last_rd, 16'h0);
    check("post_reset_gpio", gpio, 16'h0);
    cyc(0, 16'h0005, 16'h0, 1, 0);
    check("ram_survives_reset", last_rd, 16'hBEEF);

    for (int n = 0; n < 3000; n++) begin
      a = rand_addr();
      d = 16'($urandom);
      if (a == 16'hFF02) d = 16'($urandom_range(0, 6));
      cyc(($urandom_range(0, 299) == 0), a, d, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
